gat_feat_bram_reader: RTL and testbench

//   Host-side read master for the new-feature result BRAM of the GAT accelerator.
//   - After the layer completes, walks feat_bram_addrb over byte addresses 0,4,8,...
//   - Absorbs the BRAM read latency.
//   - Streams each 32-bit feature word out on a valid/ready interface, with tlast
//     on the final word, for DMA back to host memory.

---
 rtl/gat_feat_bram_reader.sv | 125 ++++++++++++
 tb/tb_gat_feat_bram_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_feat_bram_reader.sv
// Read master for the GAT new-feature BRAM: walks word addresses, absorbs the BRAM
// read latency and streams each word out on valid/ready with tlast on the final word.
module gat_feat_bram_reader #(
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NEW_FEATURE_ADDR_W = 16,
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [31:0]                   feat_bram_dout,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
);

  localparam int CNT_W = NEW_FEATURE_ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(NEW_FEATURE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] FIFO_DEPTH_C = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              n_q, rd_idx, tx_cnt, tx_cnt_nxt, n_clamp;
  logic [NEW_FEATURE_ADDR_W+1:0] addr_q;
  logic [RD_LATENCY-1:0]         tag;
  logic [31:0]                   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [OCC_W-1:0]              fifo_count, fifo_count_nxt, inflight;
  logic                          issue, push, pop, accept;

  assign n_clamp = (num_words > DEPTH_C) ? DEPTH_C : num_words;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(tag[i]);
    end
  end

  // Data is captured only when its issue tag reaches the end of the latency line.
  assign push           = tag[RD_LATENCY-1];
  assign m_tvalid       = (fifo_count != '0);
  assign pop            = m_tvalid && m_tready;
  assign m_tdata        = m_tvalid ? fifo_mem[rd_ptr] : '0;
  assign m_tlast        = m_tvalid && (tx_cnt == n_q - CNT_W'(1));
  assign fifo_count_nxt = fifo_count + OCC_W'(push) - OCC_W'(pop);
  assign tx_cnt_nxt     = tx_cnt + CNT_W'(pop);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (n_clamp == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (rd_idx == n_q) begin
          state_nxt = DRAIN;
        end else if ((inflight + fifo_count) < FIFO_DEPTH_C) begin
          issue = 1'b1;
        end
      end
      // Look at post-handshake values so done follows the last handshake directly.
      DRAIN: begin
        if (inflight == '0 && fifo_count_nxt == '0 && tx_cnt_nxt == n_q) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy            = (state == RUN) || (state == DRAIN);
  assign done            = (state == FIN);
  assign feat_bram_addrb = issue ? {rd_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00} : addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n_q        <= '0;
      rd_idx     <= '0;
      tx_cnt     <= '0;
      addr_q     <= '0;
      tag        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state      <= state_nxt;
      addr_q     <= feat_bram_addrb;
      tag        <= (tag << 1) | RD_LATENCY'(issue);
      fifo_count <= fifo_count_nxt;
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (accept) begin
        n_q    <= n_clamp;
        rd_idx <= '0;
        tx_cnt <= '0;
      end else begin
        if (issue) rd_idx <= rd_idx + CNT_W'(1);
        tx_cnt <= tx_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= feat_bram_dout;
  end

endmodule

// File: tb/tb_gat_feat_bram_reader.sv
// Directed bench for gat_feat_bram_reader; the BRAM model returns 0xA000_0000 + word index.
module tb_gat_feat_bram_reader;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 43328;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              m_tready = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              busy, done, m_tvalid, m_tlast;
  logic [ADDR_W+1:0] feat_bram_addrb;
  logic [31:0]       feat_bram_dout, m_tdata, p1, p2;

  int checks = 0;
  int failures = 0;

  logic [31:0]       h_data[$];
  bit                h_last[$];
  logic [ADDR_W+1:0] c_addr[$];
  bit                c_valid[$], c_ready[$], c_busy[$];
  logic [31:0]       c_data[$];
  int                first_valid, last_hs, done_cyc, done_cnt;
  bit                timed_out;

  gat_feat_bram_reader #(
    .NEW_FEATURE_DEPTH(DEPTH), .NEW_FEATURE_ADDR_W(ADDR_W), .RD_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .busy(busy), .done(done), .feat_bram_addrb(feat_bram_addrb),
    .feat_bram_dout(feat_bram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  // Two-stage BRAM read pipeline
  always @(posedge clk) begin
    p1 <= 32'hA000_0000 + 32'(feat_bram_addrb >> 2);
    p2 <= p1;
  end
  assign feat_bram_dout = p2;

  // Launches one transfer (start accepted in cycle 0) and records what the DUT does.
  task automatic run_transfer(input int nw, input bit toggle, input int restart_at, input int budget);
    h_data.delete(); h_last.delete(); c_addr.delete();
    c_valid.delete(); c_ready.delete(); c_busy.delete(); c_data.delete();
    first_valid = -1; last_hs = -1; done_cyc = -1; done_cnt = 0; timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1; num_words = (ADDR_W+1)'(nw); m_tready = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      m_tready = toggle ? cyc[0] : 1'b1;
      c_addr.push_back(feat_bram_addrb);
      c_valid.push_back(m_tvalid);
      c_ready.push_back(m_tready);
      c_busy.push_back(busy);
      c_data.push_back(m_tdata);
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (m_tvalid && m_tready) begin
        h_data.push_back(m_tdata);
        h_last.push_back(m_tlast);
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    if (done_cyc < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_tlast !== 1'b0 ||
          feat_bram_addrb !== '0 || m_tdata !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs[%0d] got tvalid=%b busy=%b done=%b tlast=%b addrb=%h tdata=%h, all must be 0",
                 k, m_tvalid, busy, done, m_tlast, feat_bram_addrb, m_tdata);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_stream16;
    int lc;
    run_transfer(16, 1'b0, -1, 100);
    checks++;
    if (timed_out !== 1'b0 || h_data.size() != 16) begin
      failures++;
      $display("[TB] FAIL t1_count got=%0d timeout=%b exp=16", h_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (h_data[i] !== 32'hA000_0000 + 32'(i)) begin
          failures++;
          $display("[TB] FAIL t1_data[%0d] got=%h exp=%h", i, h_data[i], 32'hA000_0000 + 32'(i));
        end
        checks++;
        if (c_addr[i] !== 18'(i * 4)) begin
          failures++;
          $display("[TB] FAIL t1_addr[cycle %0d] got=%h exp=%h", i + 1, c_addr[i], 18'(i * 4));
        end
      end
      lc = 0;
      foreach (h_last[i]) lc += int'(h_last[i]);
      checks++;
      if (lc != 1 || h_last[15] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL t1_tlast got count=%0d on_last=%b exp count=1 on_last=1", lc, h_last[15]);
      end
    end
    checks++;
    if (first_valid != 4) begin
      failures++;
      $display("[TB] FAIL t1_first_valid got=%0d exp=4", first_valid);
    end
    checks++;
    if (last_hs != 19 || done_cyc != 20 || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL t1_timing got last_hs=%0d done=%0d pulses=%0d exp 19/20/1", last_hs, done_cyc, done_cnt);
    end
    checks++;
    if (c_busy[0] !== 1'b1 || (done_cyc > 0 && c_busy[done_cyc-1] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL t1_busy got first=%b at_done=%b exp 1/0", c_busy[0],
               (done_cyc > 0) ? c_busy[done_cyc-1] : 1'b1);
    end
  endtask

  task automatic test_backpressure;
    run_transfer(8, 1'b1, -1, 100);
    checks++;
    if (timed_out !== 1'b0 || h_data.size() != 8) begin
      failures++;
      $display("[TB] FAIL t2_count got=%0d timeout=%b exp=8", h_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (h_data[i] !== 32'hA000_0000 + 32'(i) || h_last[i] !== (i == 7)) begin
          failures++;
          $display("[TB] FAIL t2_word[%0d] got=%h last=%b exp=%h last=%b", i, h_data[i], h_last[i],
                   32'hA000_0000 + 32'(i), (i == 7));
        end
      end
    end
    for (int k = 0; k + 1 < c_valid.size(); k++) begin
      if (c_valid[k] && !c_ready[k]) begin
        checks++;
        if (!c_valid[k+1] || c_data[k+1] !== c_data[k]) begin
          failures++;
          $display("[TB] FAIL t2_stall_hold[cycle %0d] got valid=%b data=%h exp valid=1 data=%h",
                   k + 2, c_valid[k+1], c_data[k+1], c_data[k]);
        end
      end
    end
    checks++;
    if (done_cyc != last_hs + 1 || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL t2_done got done=%0d pulses=%0d exp done=%0d pulses=1", done_cyc, done_cnt, last_hs + 1);
    end
  endtask

  task automatic test_zero_words;
    bit any_busy = 1'b0;
    run_transfer(0, 1'b0, -1, 20);
    foreach (c_busy[i]) any_busy |= c_busy[i];
    checks++;
    if (timed_out !== 1'b0 || done_cnt != 1 || done_cyc < 1 || done_cyc > 2) begin
      failures++;
      $display("[TB] FAIL t3_done got cycle=%0d pulses=%0d exp cycle 1..2 pulses=1", done_cyc, done_cnt);
    end
    checks++;
    if (first_valid != -1 || h_data.size() != 0 || any_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t3_quiet got first_valid=%0d words=%0d busy_seen=%b exp -1/0/0",
               first_valid, h_data.size(), any_busy);
    end
  endtask

  task automatic test_clamp;
    logic [ADDR_W+1:0] max_addr = '0;
    int lc = 0;
    run_transfer(50000, 1'b0, -1, DEPTH + 100);
    checks++;
    if (timed_out !== 1'b0 || h_data.size() != DEPTH) begin
      failures++;
      $display("[TB] FAIL t4_count got=%0d timeout=%b exp=%0d", h_data.size(), timed_out, DEPTH);
    end else begin
      foreach (h_last[i]) lc += int'(h_last[i]);
      checks++;
      if (h_data[DEPTH-1] !== 32'hA000_0000 + 32'(DEPTH - 1) || h_last[DEPTH-1] !== 1'b1 || lc != 1) begin
        failures++;
        $display("[TB] FAIL t4_last_word got=%h last=%b lasts=%0d exp=%h last=1 lasts=1",
                 h_data[DEPTH-1], h_last[DEPTH-1], lc, 32'hA000_0000 + 32'(DEPTH - 1));
      end
    end
    foreach (c_addr[i]) if (c_addr[i] > max_addr) max_addr = c_addr[i];
    checks++;
    if (max_addr !== 18'h2A4FC) begin
      failures++;
      $display("[TB] FAIL t4_max_addr got=%h exp=2a4fc", max_addr);
    end
  endtask

  task automatic test_reset_mid;
    int hs = 0;
    @(negedge clk);
    start = 1'b1; num_words = 17'd16; m_tready = 1'b1;
    for (int cyc = 1; cyc <= 60 && hs < 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_tvalid && m_tready) hs++;
    end
    checks++;
    if (hs != 5) begin
      failures++;
      $display("[TB] FAIL t5_reach5 got=%0d exp=5", hs);
    end
    @(negedge clk);
    m_tready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t5_after_rst got tvalid=%b busy=%b done=%b exp 0/0/0", m_tvalid, busy, done);
    end
    run_transfer(4, 1'b0, -1, 60);
    checks++;
    if (timed_out !== 1'b0 || h_data.size() != 4) begin
      failures++;
      $display("[TB] FAIL t5_count got=%0d timeout=%b exp=4", h_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (h_data[i] !== 32'hA000_0000 + 32'(i)) begin
          failures++;
          $display("[TB] FAIL t5_data[%0d] got=%h exp=%h", i, h_data[i], 32'hA000_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_restart_ignored;
    run_transfer(16, 1'b0, 6, 100);
    checks++;
    if (timed_out !== 1'b0 || h_data.size() != 16) begin
      failures++;
      $display("[TB] FAIL t6_count got=%0d timeout=%b exp=16", h_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (h_data[i] !== 32'hA000_0000 + 32'(i)) begin
          failures++;
          $display("[TB] FAIL t6_data[%0d] got=%h exp=%h", i, h_data[i], 32'hA000_0000 + 32'(i));
        end
      end
    end
    checks++;
    if (done_cyc != 20 || done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL t6_done got cycle=%0d pulses=%0d exp 20/1", done_cyc, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream16();
    test_backpressure();
    test_zero_words();
    test_clamp();
    test_reset_mid();
    test_restart_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
